// File: rtl/line_buffer_ctrl_pkg.sv
// Shared definitions for the 3x3 edge-kernel front end: sequencer states and
// default frame geometry used by the line buffers, kernel and this controller.
package line_buffer_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } lb_state_e;

    localparam int LINE_LEN_DEF   = 78;
    localparam int ADDR_W_DEF     = 7;
    localparam int FRAME_ROWS_DEF = 60;
    localparam int ROW_W_DEF      = 6;
    localparam int DATA_W_DEF     = 32;

    // Rows that must be loaded before the first full 3x3 window exists.
    localparam int FILL_ROWS = 2;

endpackage

// File: rtl/line_buffer_ctrl_if.sv
// Raster pixel stream with valid/ready handshake between the upstream source
// and the line-buffer controller.
interface line_buffer_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              pix_valid;
    logic [DATA_W-1:0] pix_data;
    logic              pix_ready;

    modport master (output pix_valid, output pix_data, input pix_ready);
    modport slave  (input pix_valid, input pix_data, output pix_ready);
endinterface

// File: rtl/line_buffer_ctrl_raster_counter.sv
// Column/row raster position counter; advances once per accepted pixel and
// wraps both coordinates at the end of a frame.
module line_buffer_ctrl_raster_counter #(
    parameter int LINE_LEN   = 78,
    parameter int FRAME_ROWS = 60,
    parameter int ADDR_W     = 7,
    parameter int ROW_W      = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              advance,
    output logic [ADDR_W-1:0] col,
    output logic [ROW_W-1:0]  row,
    output logic              last_col,
    output logic              last_pix
);

    logic [ADDR_W-1:0] col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;

    assign last_col = (col_q == ADDR_W'(LINE_LEN - 1));
    assign last_pix = last_col && (row_q == ROW_W'(FRAME_ROWS - 1));
    assign col      = col_q;
    assign row      = row_q;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (advance) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_pix ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/line_buffer_ctrl.sv
// Sequencer for the two cascaded line buffers feeding the 3x3 edge kernel:
// write strobe/address generation, window-valid tracking and frame markers.
module line_buffer_ctrl
    import line_buffer_ctrl_pkg::*;
#(
    parameter int LINE_LEN   = LINE_LEN_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int FRAME_ROWS = FRAME_ROWS_DEF,
    parameter int ROW_W      = ROW_W_DEF,
    parameter int DATA_W     = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    line_buffer_ctrl_if.slave   pix,
    input  logic                lb_ready,
    output logic                lb_write_en,
    output logic [ADDR_W-1:0]   lb_wr_addr,
    output logic [DATA_W-1:0]   lb_wr_data,
    output logic                win_valid,
    output logic [ADDR_W-1:0]   win_col,
    output logic [ROW_W-1:0]    win_row,
    output logic                sof,
    output logic                frame_done
);

    lb_state_e         state_q, state_d;
    logic              accept, win_hit;
    logic [ADDR_W-1:0] col;
    logic [ROW_W-1:0]  row;
    logic              last_col, last_pix;

    logic              win_valid_q, win_valid_d;
    logic [ADDR_W-1:0] win_col_q, win_col_d;
    logic [ROW_W-1:0]  win_row_q, win_row_d;
    logic              sof_q, sof_d;
    logic              frame_done_q, frame_done_d;

    assign pix.pix_ready = (state_q != ST_IDLE) && lb_ready;
    assign accept        = pix.pix_valid && pix.pix_ready;
    assign lb_write_en   = accept;
    assign lb_wr_addr    = col;
    assign lb_wr_data    = pix.pix_data;

    line_buffer_ctrl_raster_counter #(
        .LINE_LEN   (LINE_LEN),
        .FRAME_ROWS (FRAME_ROWS),
        .ADDR_W     (ADDR_W),
        .ROW_W      (ROW_W)
    ) u_raster (
        .clk      (clk),
        .rst      (rst),
        .advance  (accept),
        .col      (col),
        .row      (row),
        .last_col (last_col),
        .last_pix (last_pix)
    );

    // Border columns 0..1 and the first two rows never complete a window.
    assign win_hit = accept && (row >= ROW_W'(FILL_ROWS)) && (col >= ADDR_W'(2));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start) state_d = ST_FILL;
            ST_FILL: begin
                if (accept && last_pix)
                    state_d = ST_IDLE;
                else if (accept && last_col && row == ROW_W'(FILL_ROWS - 1))
                    state_d = ST_RUN;
            end
            ST_RUN:  if (accept && last_pix) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        win_valid_d  = win_hit;
        win_col_d    = win_col_q;
        win_row_d    = win_row_q;
        sof_d        = win_hit && (row == ROW_W'(FILL_ROWS)) && (col == ADDR_W'(2));
        frame_done_d = accept && last_pix;
        if (win_hit) begin
            win_col_d = col - ADDR_W'(1);
            win_row_d = row - ROW_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            win_valid_q  <= 1'b0;
            win_col_q    <= '0;
            win_row_q    <= '0;
            sof_q        <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            win_valid_q  <= win_valid_d;
            win_col_q    <= win_col_d;
            win_row_q    <= win_row_d;
            sof_q        <= sof_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign win_valid  = win_valid_q;
    assign win_col    = win_col_q;
    assign win_row    = win_row_q;
    assign sof        = sof_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Directed bench: small 8x4 frame instance for detailed checks plus a
// default-geometry instance for the full-frame window count.
module tb_line_buffer_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- small instance: 8 x 4 ----------------
    logic        start = 1'b0;
    logic        lb_ready = 1'b1;
    logic        lb_write_en;
    logic [6:0]  lb_wr_addr;
    logic [31:0] lb_wr_data;
    logic        win_valid;
    logic [6:0]  win_col;
    logic [5:0]  win_row;
    logic        sof;
    logic        frame_done;

    line_buffer_ctrl_if #(.DATA_W(32)) s_if ();

    line_buffer_ctrl #(
        .LINE_LEN(8), .ADDR_W(7), .FRAME_ROWS(4), .ROW_W(6), .DATA_W(32)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .pix(s_if),
        .lb_ready(lb_ready), .lb_write_en(lb_write_en),
        .lb_wr_addr(lb_wr_addr), .lb_wr_data(lb_wr_data),
        .win_valid(win_valid), .win_col(win_col), .win_row(win_row),
        .sof(sof), .frame_done(frame_done)
    );

    // line-buffer model: ready drops for one cycle after every write
    always @(posedge clk) lb_ready <= rst ? 1'b1 : !lb_write_en;

    // ---------------- default-geometry instance: 78 x 60 ----------------
    logic        b_start = 1'b0;
    logic        b_lb_ready = 1'b1;
    logic        b_write_en;
    logic [6:0]  b_wr_addr;
    logic [31:0] b_wr_data;
    logic        b_win_valid;
    logic [6:0]  b_win_col;
    logic [5:0]  b_win_row;
    logic        b_sof;
    logic        b_frame_done;

    line_buffer_ctrl_if #(.DATA_W(32)) b_if ();

    line_buffer_ctrl big (
        .clk(clk), .rst(rst), .start(b_start), .pix(b_if),
        .lb_ready(b_lb_ready), .lb_write_en(b_write_en),
        .lb_wr_addr(b_wr_addr), .lb_wr_data(b_wr_data),
        .win_valid(b_win_valid), .win_col(b_win_col), .win_row(b_win_row),
        .sof(b_sof), .frame_done(b_frame_done)
    );

    always @(posedge clk) b_lb_ready <= rst ? 1'b1 : !b_write_en;

    // ---------------- observation (negedge, away from active edge) ----------------
    int m_wr_cnt, m_wr_nr, m_addr_err, m_data_err;
    int m_win_cnt, m_sof_cnt, m_fd_cnt, m_fd_at, m_orphan;
    int m_first_col, m_first_row, m_first_sof, m_last_col, m_last_row;
    bit m_prev_wr;
    int m_win_q[$];

    int b_wr_cnt = 0, b_wr_nr = 0, b_win_cnt = 0, b_sof_cnt = 0, b_fd_cnt = 0;

    always @(negedge clk) begin
        if (lb_write_en) begin
            if (!lb_ready) m_wr_nr++;
            if (lb_wr_addr !== 7'(m_wr_cnt % 8)) m_addr_err++;
            if (lb_wr_data !== s_if.pix_data) m_data_err++;
            m_wr_cnt++;
        end
        if (win_valid) begin
            if (!m_prev_wr) m_orphan++;
            if (m_win_cnt == 0) begin
                m_first_col = int'(win_col);
                m_first_row = int'(win_row);
                m_first_sof = int'(sof);
            end
            m_last_col = int'(win_col);
            m_last_row = int'(win_row);
            m_win_q.push_back(int'(win_row) * 256 + int'(win_col));
            m_win_cnt++;
        end
        if (sof) m_sof_cnt++;
        if (frame_done) begin
            m_fd_cnt++;
            m_fd_at = m_wr_cnt;
        end
        m_prev_wr = lb_write_en;

        if (b_write_en) begin
            if (!b_lb_ready) b_wr_nr++;
            b_wr_cnt++;
        end
        if (b_win_valid) b_win_cnt++;
        if (b_sof) b_sof_cnt++;
        if (b_frame_done) b_fd_cnt++;
    end

    task automatic clear_mon();
        m_wr_cnt = 0; m_wr_nr = 0; m_addr_err = 0; m_data_err = 0;
        m_win_cnt = 0; m_sof_cnt = 0; m_fd_cnt = 0; m_fd_at = -1; m_orphan = 0;
        m_first_col = -1; m_first_row = -1; m_first_sof = -1;
        m_last_col = -1; m_last_row = -1; m_prev_wr = 1'b0;
        m_win_q.delete();
    endtask

    // expected window sequence for an 8x4 frame: centres rows 1..2, cols 1..6
    function automatic int win_list_errs();
        int k = 0;
        int e = 0;
        if (m_win_q.size() != 12) e++;
        for (int r = 1; r <= 2; r++)
            for (int c = 1; c <= 6; c++) begin
                if (k >= m_win_q.size() || m_win_q[k] != r * 256 + c) e++;
                k++;
            end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic stream(input int n, input int max_gap);
        for (int i = 0; i < n; i++) begin
            int waited;
            bit done;
            waited = 0;
            done   = 1'b0;
            s_if.pix_valid = 1'b1;
            s_if.pix_data  = 32'hA500_0000 + 32'(i);
            while (!done) begin
                @(negedge clk);
                if (s_if.pix_ready) done = 1'b1;
                tick();
                waited++;
                if (!done && waited > 20) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL stream_timeout: pixel %0d not accepted after %0d cycles, required <= 20", i, waited);
                    s_if.pix_valid = 1'b0;
                    return;
                end
            end
            s_if.pix_valid = 1'b0;
            if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) tick();
        end
    endtask

    task automatic check_frame_results(input string tag);
        int errs;
        errs = win_list_errs();
        n_tests++; if (m_wr_cnt !== 32)  begin n_fail++; $display("FAIL %s_writes: got %0d expected 32", tag, m_wr_cnt); end
        n_tests++; if (m_wr_nr !== 0)    begin n_fail++; $display("FAIL %s_write_not_ready: got %0d expected 0", tag, m_wr_nr); end
        n_tests++; if (m_addr_err !== 0) begin n_fail++; $display("FAIL %s_addr: got %0d bad addresses expected 0", tag, m_addr_err); end
        n_tests++; if (m_data_err !== 0) begin n_fail++; $display("FAIL %s_data: got %0d bad data expected 0", tag, m_data_err); end
        n_tests++; if (m_fd_cnt !== 1 || m_fd_at !== 32) begin n_fail++; $display("FAIL %s_frame_done: got count %0d at write %0d expected 1 at 32", tag, m_fd_cnt, m_fd_at); end
        n_tests++; if (m_win_cnt !== 12) begin n_fail++; $display("FAIL %s_win_count: got %0d expected 12", tag, m_win_cnt); end
        n_tests++; if (m_sof_cnt !== 1 || m_first_sof !== 1) begin n_fail++; $display("FAIL %s_sof: got count %0d first %0d expected 1 1", tag, m_sof_cnt, m_first_sof); end
        n_tests++; if (m_first_row !== 1 || m_first_col !== 1) begin n_fail++; $display("FAIL %s_first_win: got r%0d c%0d expected r1 c1", tag, m_first_row, m_first_col); end
        n_tests++; if (m_last_row !== 2 || m_last_col !== 6) begin n_fail++; $display("FAIL %s_last_win: got r%0d c%0d expected r2 c6", tag, m_last_row, m_last_col); end
        n_tests++; if (errs !== 0)       begin n_fail++; $display("FAIL %s_win_list: got %0d wrong entries expected 0", tag, errs); end
        n_tests++; if (m_orphan !== 0)   begin n_fail++; $display("FAIL %s_win_no_accept: got %0d expected 0", tag, m_orphan); end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_tests++;
        if ({win_valid, sof, frame_done, s_if.pix_ready} !== 4'b0 || win_col !== 7'd0 || win_row !== 6'd0 || lb_wr_addr !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got wv=%b sof=%b fd=%b rdy=%b col=%0d row=%0d addr=%0d expected all 0",
                     win_valid, sof, frame_done, s_if.pix_ready, win_col, win_row, lb_wr_addr);
        end
        tick();
        s_if.pix_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_tests++;
            if (s_if.pix_ready !== 1'b0 || lb_write_en !== 1'b0) begin
                n_fail++;
                $display("FAIL no_start_accept: got ready=%b we=%b expected 0 0", s_if.pix_ready, lb_write_en);
            end
            tick();
        end
        s_if.pix_valid = 1'b0;
    endtask

    task automatic test_frame();
        clear_mon();
        do_start();
        stream(32, 0);
        repeat (3) tick();
        check_frame_results("frame");
        @(negedge clk);
        n_tests++;
        if (s_if.pix_ready !== 1'b0) begin n_fail++; $display("FAIL idle_after_frame: got ready=%b expected 0", s_if.pix_ready); end
        tick();
    endtask

    task automatic test_gaps();
        clear_mon();
        do_start();
        stream(32, 3);
        repeat (3) tick();
        check_frame_results("gaps");
    endtask

    task automatic test_rst_mid();
        clear_mon();
        do_start();
        stream(20, 0);
        rst = 1'b1;
        s_if.pix_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({win_valid, sof, frame_done, s_if.pix_ready, lb_write_en} !== 5'b0 || win_col !== 7'd0 || win_row !== 6'd0 || lb_wr_addr !== 7'd0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: got wv=%b sof=%b fd=%b rdy=%b we=%b col=%0d row=%0d addr=%0d expected all 0",
                     win_valid, sof, frame_done, s_if.pix_ready, lb_write_en, win_col, win_row, lb_wr_addr);
        end
        tick();
        rst = 1'b0;
        s_if.pix_valid = 1'b0;
        tick();
        clear_mon();
        do_start();
        stream(32, 0);
        repeat (3) tick();
        check_frame_results("after_rst");
    endtask

    task automatic test_start_ignored();
        clear_mon();
        do_start();
        stream(18, 0);
        do_start();
        stream(14, 0);
        start = 1'b1;
        @(negedge clk);
        n_tests++;
        if (frame_done !== 1'b1) begin n_fail++; $display("FAIL fd_with_start: got frame_done=%b expected 1", frame_done); end
        tick();
        start = 1'b0;
        @(negedge clk);
        n_tests++;
        if (s_if.pix_ready !== 1'b1) begin n_fail++; $display("FAIL start_on_fd: got ready=%b expected 1", s_if.pix_ready); end
        n_tests++;
        if (m_wr_cnt !== 32 || m_win_cnt !== 12 || m_fd_cnt !== 1) begin
            n_fail++;
            $display("FAIL start_in_run: got writes=%0d wins=%0d fd=%0d expected 32 12 1", m_wr_cnt, m_win_cnt, m_fd_cnt);
        end
        tick();
        clear_mon();
        stream(32, 0);
        repeat (3) tick();
        check_frame_results("restart");
    endtask

    task automatic test_default_params();
        tick();
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int i = 0; i < 78 * 60; i++) begin
            int waited;
            bit done;
            waited = 0;
            done   = 1'b0;
            b_if.pix_valid = 1'b1;
            b_if.pix_data  = 32'(i);
            while (!done) begin
                @(negedge clk);
                if (b_if.pix_ready) done = 1'b1;
                tick();
                waited++;
                if (!done && waited > 20) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL big_timeout: pixel %0d not accepted after %0d cycles, required <= 20", i, waited);
                    b_if.pix_valid = 1'b0;
                    return;
                end
            end
            b_if.pix_valid = 1'b0;
        end
        repeat (3) tick();
        n_tests++; if (b_wr_cnt !== 4680) begin n_fail++; $display("FAIL big_writes: got %0d expected 4680", b_wr_cnt); end
        n_tests++; if (b_wr_nr !== 0)     begin n_fail++; $display("FAIL big_write_not_ready: got %0d expected 0", b_wr_nr); end
        n_tests++; if (b_win_cnt !== 4408) begin n_fail++; $display("FAIL big_win_count: got %0d expected 4408", b_win_cnt); end
        n_tests++; if (b_sof_cnt !== 1 || b_fd_cnt !== 1) begin n_fail++; $display("FAIL big_markers: got sof=%0d fd=%0d expected 1 1", b_sof_cnt, b_fd_cnt); end
    endtask

    initial begin
        s_if.pix_valid = 1'b0;
        s_if.pix_data  = '0;
        b_if.pix_valid = 1'b0;
        b_if.pix_data  = '0;
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_frame();
        test_gaps();
        test_rst_mid();
        test_start_ignored();
        test_default_params();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion before limit");
        $fatal(1, "watchdog");
    end

endmodule
